// File: rtl/booth_mult_stream_ctrl.sv
// Valid/ready front-end and result FIFO around a pipelined 16x16 Booth multiplier core.
// Optional per-transaction tag pass-through is enabled with `define BOOTH_STREAM_TAG_EN.
module booth_mult_stream_ctrl #(
    parameter int MULT_LAT = 2,
    parameter int DEPTH    = 8,
    parameter int TAG_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
`ifdef BOOTH_STREAM_TAG_EN
    input  logic [TAG_W-1:0]         in_tag,
`endif
    output logic [15:0]              mult_a,
    output logic [15:0]              mult_b,
    input  logic [31:0]              mult_product,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_product,
`ifdef BOOTH_STREAM_TAG_EN
    output logic [TAG_W-1:0]         out_tag,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    if (DEPTH < MULT_LAT + 2 || (DEPTH & (DEPTH - 1)) != 0 || MULT_LAT < 1 || TAG_W < 1) begin : g_bad_cfg
        $error("booth_mult_stream_ctrl: illegal DEPTH/MULT_LAT/TAG_W combination");
    end

    logic                 accept;
    logic                 pop;
    logic                 push;
    logic                 iss_v;
    logic [MULT_LAT-1:0]  lat_v;
    logic [OCC_W-1:0]     occ;
    logic [OCC_W-1:0]     count;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [31:0]          mem_prod [DEPTH];

    assign accept      = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign push        = lat_v[MULT_LAT-1];
    // Credits come from the registered count only; a same-cycle pop frees nothing yet.
    assign in_ready    = (occ < OCC_FULL);
    assign occupancy   = occ;
    assign out_valid   = (count != {OCC_W{1'b0}});
    assign out_product = mem_prod[rd_ptr];

    // Operand capture onto the core and issue tracking through its fixed latency
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_a <= 16'd0;
            mult_b <= 16'd0;
            iss_v  <= 1'b0;
            lat_v  <= {MULT_LAT{1'b0}};
        end else begin
            if (accept) begin
                mult_a <= in_a;
                mult_b <= in_b;
            end
            iss_v    <= accept;
            lat_v[0] <= iss_v;
            for (int i = 1; i < MULT_LAT; i++) begin
                lat_v[i] <= lat_v[i-1];
            end
        end
    end

    // Credit counter: in-flight plus buffered results
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= {OCC_W{1'b0}};
        end else begin
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_ONE;
                2'b01:   occ <= occ - OCC_ONE;
                default: occ <= occ;
            endcase
        end
    end

    // Result FIFO, first-word fall-through; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= {PTR_W{1'b0}};
            rd_ptr <= {PTR_W{1'b0}};
            count  <= {OCC_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_prod[i] <= 32'd0;
            end
        end else begin
            if (push) begin
                mem_prod[wr_ptr] <= mult_product;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + OCC_ONE;
                2'b01:   count <= count - OCC_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef BOOTH_STREAM_TAG_EN
    logic [TAG_W-1:0] tag_pipe [MULT_LAT+1];
    logic [TAG_W-1:0] mem_tag  [DEPTH];

    assign out_tag = mem_tag[rd_ptr];

    // Tag rides alongside iss_v/lat_v so stage MULT_LAT lines up with the push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MULT_LAT; i++) begin
                tag_pipe[i] <= {TAG_W{1'b0}};
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_tag[i] <= {TAG_W{1'b0}};
            end
        end else begin
            if (accept) begin
                tag_pipe[0] <= in_tag;
            end
            for (int i = 1; i <= MULT_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            if (push) begin
                mem_tag[wr_ptr] <= tag_pipe[MULT_LAT];
            end
        end
    end
`endif

endmodule
